// File: rtl/ram_arb_pkg.sv
// Shared types for the two-host single-port RAM arbiter and its round-robin core.
package ram_arb_pkg;

    localparam int unsigned NumHosts = 2;

    typedef logic host_idx_t;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_RAM  = 2'd1,
        RSP_ERR  = 2'd2
    } rsp_src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on conflict the host that did not win last time wins.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output host_idx_t  idx_o,
    output logic       valid_o
);

    host_idx_t last_q;

    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            idx_o = ~last_q;
        end else begin
            idx_o = req_i[1];
        end
        gnt_o = 2'b00;
        if (valid_o) begin
            gnt_o = idx_o ? 2'b10 : 2'b01;
        end
    end

    // Reset to host 1 so that host 0 takes the first conflict.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (valid_o) begin
            last_q <= idx_o;
        end
    end

endmodule

// File: rtl/ram_1p_arbiter.sv
// Shares one single-port 32-bit SRAM between two hosts with round-robin arbitration,
// range checking with a local error response, and 1-cycle response routing.
module ram_1p_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0010_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumHosts-1:0]    host_req_i,
    output logic [NumHosts-1:0]    host_gnt_o,
    input  logic [NumHosts-1:0]    host_we_i,
    input  logic [4*NumHosts-1:0]  host_be_i,
    input  logic [32*NumHosts-1:0] host_addr_i,
    input  logic [32*NumHosts-1:0] host_wdata_i,
    output logic [NumHosts-1:0]    host_rvalid_o,
    output logic [NumHosts-1:0]    host_err_o,
    output logic [32*NumHosts-1:0] host_rdata_o,
    output logic                   ram_req_o,
    output logic                   ram_we_o,
    output logic [3:0]             ram_be_o,
    output logic [31:0]            ram_addr_o,
    output logic [31:0]            ram_wdata_o,
    input  logic                   ram_rvalid_i,
    input  logic [31:0]            ram_rdata_i
);

    localparam logic [31:0] RangeBytes = 32'(Depth * 4);

    logic [1:0]  req_gated;
    logic [1:0]  gnt;
    host_idx_t   win;
    logic        win_valid;
    logic        win_we;
    logic [3:0]  win_be;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [31:0] offset;
    logic        in_range;
    logic        ram_grant;
    logic        err_grant;

    logic        ram_pend_q;
    logic        err_pend_q;
    host_idx_t   ram_owner_q;
    host_idx_t   err_owner_q;
    rsp_src_e    rsp_src;

    assign req_gated = host_req_i & {2{rst_ni}};

    rr_arb2 u_rr_arb2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (req_gated),
        .gnt_o   (gnt),
        .idx_o   (win),
        .valid_o (win_valid)
    );

    assign host_gnt_o = gnt;

    always_comb begin
        if (win) begin
            win_we    = host_we_i[1];
            win_be    = host_be_i[7:4];
            win_addr  = host_addr_i[63:32];
            win_wdata = host_wdata_i[63:32];
        end else begin
            win_we    = host_we_i[0];
            win_be    = host_be_i[3:0];
            win_addr  = host_addr_i[31:0];
            win_wdata = host_wdata_i[31:0];
        end
    end

    // Unsigned wrap pushes addresses below BaseAddr out of range as well.
    assign offset    = win_addr - BaseAddr;
    assign in_range  = offset < RangeBytes;
    assign ram_grant = win_valid & in_range;
    assign err_grant = win_valid & ~in_range;

    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = 32'h0;
        if (ram_grant) begin
            ram_req_o   = 1'b1;
            ram_we_o    = win_we;
            ram_be_o    = win_be;
            ram_addr_o  = offset;
            ram_wdata_o = win_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ram_pend_q  <= 1'b0;
            err_pend_q  <= 1'b0;
            ram_owner_q <= 1'b0;
            err_owner_q <= 1'b0;
        end else begin
            ram_pend_q <= ram_grant;
            err_pend_q <= err_grant;
            if (ram_grant) begin
                ram_owner_q <= win;
            end
            if (err_grant) begin
                err_owner_q <= win;
            end
        end
    end

    // Responses are suppressed while in reset so a grant just before reset gets none.
    always_comb begin
        rsp_src = RSP_NONE;
        if (rst_ni) begin
            if (ram_pend_q) begin
                rsp_src = RSP_RAM;
            end else if (err_pend_q) begin
                rsp_src = RSP_ERR;
            end
        end
    end

    always_comb begin
        host_rvalid_o = '0;
        host_err_o    = '0;
        host_rdata_o  = '0;
        for (int h = 0; h < NumHosts; h++) begin
            case (rsp_src)
                RSP_RAM: begin
                    if (ram_owner_q == host_idx_t'(h)) begin
                        host_rvalid_o[h]        = ram_rvalid_i;
                        host_rdata_o[32*h +: 32] = ram_rvalid_i ? ram_rdata_i : 32'h0;
                    end
                end
                RSP_ERR: begin
                    if (err_owner_q == host_idx_t'(h)) begin
                        host_rvalid_o[h] = 1'b1;
                        host_err_o[h]    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_1p_arbiter.sv
// Directed vector bench for ram_1p_arbiter with a behavioural 1-cycle ram_1p model.
module tb_ram_1p_arbiter;

    localparam logic [31:0] B = 32'h0010_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, we;
    logic [7:0]  be;
    logic [63:0] addr, wdata;
    logic [1:0]  gnt, rvalid, err;
    logic [63:0] rdata;
    logic        ram_req, ram_we, ram_rvalid;
    logic [3:0]  ram_be;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic [31:0] mem [128];
    logic        mem_loaded = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = 32'h0;
    logic        inject = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_1p_arbiter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .host_req_i   (req),
        .host_gnt_o   (gnt),
        .host_we_i    (we),
        .host_be_i    (be),
        .host_addr_i  (addr),
        .host_wdata_i (wdata),
        .host_rvalid_o(rvalid),
        .host_err_o   (err),
        .host_rdata_o (rdata),
        .ram_req_o    (ram_req),
        .ram_we_o     (ram_we),
        .ram_be_o     (ram_be),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_rvalid_i (ram_rvalid),
        .ram_rdata_i  (ram_rdata)
    );

    assign ram_rvalid = m_rvalid | inject;
    assign ram_rdata  = m_rdata;

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + i;
            mem[2] <= 32'hDEAD_BEEF;
            mem[4] <= 32'h1122_3344;
            mem_loaded <= 1'b1;
        end else begin
            m_rvalid <= ram_req;
            m_rdata  <= 32'h0;
            if (ram_req) begin
                if (ram_we) begin
                    for (int b = 0; b < 4; b++)
                        if (ram_be[b]) mem[ram_addr[8:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end else begin
                    m_rdata <= mem[ram_addr[8:2]];
                end
            end
        end
    end

    typedef struct {
        logic        rst_n;
        logic [1:0]  req, we;
        logic [7:0]  be;
        logic [31:0] a0, a1, wd0, wd1;
        logic [1:0]  gnt;
        logic        rreq, rwe;
        logic [3:0]  rbe;
        logic [31:0] raddr, rwdata;
        logic [1:0]  rv, er;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rs, input logic [1:0] rq, input logic [1:0] w, input logic [7:0] bb,
        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] d0, input logic [31:0] d1,
        input logic [1:0] g, input logic rr, input logic rw, input logic [3:0] rb,
        input logic [31:0] ra, input logic [31:0] rwd, input logic [1:0] v, input logic [1:0] e,
        input logic [31:0] r0, input logic [31:0] r1);
        vec_t t;
        t.rst_n = rs; t.req = rq; t.we = w; t.be = bb;
        t.a0 = a0; t.a1 = a1; t.wd0 = d0; t.wd1 = d1;
        t.gnt = g; t.rreq = rr; t.rwe = rw; t.rbe = rb;
        t.raddr = ra; t.rwdata = rwd; t.rv = v; t.er = e; t.rd0 = r0; t.rd1 = r1;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        rst_n = t.rst_n; req = t.req; we = t.we; be = t.be;
        addr = {t.a1, t.a0}; wdata = {t.wd1, t.wd0};
    endtask

    task automatic check(input string name, input vec_t t);
        logic [139:0] got, exp;
        got = {gnt, ram_req, ram_we, ram_be, ram_addr, ram_wdata, rvalid, err, rdata};
        exp = {t.gnt, t.rreq, t.rwe, t.rbe, t.raddr, t.rwdata, t.rv, t.er, t.rd1, t.rd0};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t t;
        logic [1:0] prev_g;
        logic all_ok;

        // Reset, single reads, 4-cycle conflict
        vq.push_back(mk(0,2'b11,2'b00,8'hFF,B,B+4,0,0,                 2'b00,0,0,4'h0,32'h0,0,        2'b00,2'b00,0,0));
        vq.push_back(mk(1,2'b01,2'b00,8'hFF,B+8,B+4,0,0,               2'b01,1,0,4'hF,32'h8,0,        2'b00,2'b00,0,0));
        vq.push_back(mk(1,2'b10,2'b00,8'hFF,B+8,B+32'hC,0,0,           2'b10,1,0,4'hF,32'hC,0,        2'b01,2'b00,32'hDEADBEEF,0));
        vq.push_back(mk(1,2'b11,2'b00,8'hFF,B,B+4,0,0,                 2'b01,1,0,4'hF,32'h0,0,        2'b10,2'b00,0,32'h10000003));
        vq.push_back(mk(1,2'b11,2'b00,8'hFF,B,B+4,0,0,                 2'b10,1,0,4'hF,32'h4,0,        2'b01,2'b00,32'h10000000,0));
        vq.push_back(mk(1,2'b11,2'b00,8'hFF,B,B+4,0,0,                 2'b01,1,0,4'hF,32'h0,0,        2'b10,2'b00,0,32'h10000001));
        vq.push_back(mk(1,2'b11,2'b00,8'hFF,B,B+4,0,0,                 2'b10,1,0,4'hF,32'h4,0,        2'b01,2'b00,32'h10000000,0));
        vq.push_back(mk(1,2'b00,2'b00,8'hFF,B,B+4,0,0,                 2'b00,0,0,4'h0,32'h0,0,        2'b10,2'b00,0,32'h10000001));
        // Partial write then read-back
        vq.push_back(mk(1,2'b10,2'b10,8'h3F,B,B+32'h10,0,32'hAABBCCDD, 2'b10,1,1,4'h3,32'h10,32'hAABBCCDD, 2'b00,2'b00,0,0));
        vq.push_back(mk(1,2'b01,2'b00,8'hFF,B+32'h10,B+32'h10,0,0,     2'b01,1,0,4'hF,32'h10,0,       2'b10,2'b00,0,0));
        vq.push_back(mk(1,2'b00,2'b00,8'hFF,B,B,0,0,                   2'b00,0,0,4'h0,32'h0,0,        2'b01,2'b00,32'h1122CCDD,0));
        // Out-of-range: one past end, and below base with a write
        vq.push_back(mk(1,2'b10,2'b00,8'hFF,B,B+32'h200,0,0,           2'b10,0,0,4'h0,32'h0,0,        2'b00,2'b00,0,0));
        vq.push_back(mk(1,2'b10,2'b10,8'hFF,B,32'h000FFFFC,0,32'hFFFFFFFF, 2'b10,0,0,4'h0,32'h0,0,    2'b10,2'b10,0,0));
        vq.push_back(mk(1,2'b00,2'b00,8'hFF,B,B,0,0,                   2'b00,0,0,4'h0,32'h0,0,        2'b10,2'b10,0,0));
        // Interleaved in-range host0 / out-of-range host1, including last valid word
        vq.push_back(mk(1,2'b01,2'b00,8'hFF,B+32'h1FC,B,0,0,           2'b01,1,0,4'hF,32'h1FC,0,      2'b00,2'b00,0,0));
        vq.push_back(mk(1,2'b10,2'b00,8'hFF,B,B+32'h200,0,0,           2'b10,0,0,4'h0,32'h0,0,        2'b01,2'b00,32'h1000007F,0));
        vq.push_back(mk(1,2'b01,2'b00,8'hFF,B,B+32'h200,0,0,           2'b01,1,0,4'hF,32'h0,0,        2'b10,2'b10,0,0));
        vq.push_back(mk(1,2'b10,2'b00,8'hFF,B,32'h0,0,0,               2'b10,0,0,4'h0,32'h0,0,        2'b01,2'b00,32'h10000000,0));
        vq.push_back(mk(1,2'b00,2'b00,8'hFF,B,B,0,0,                   2'b00,0,0,4'h0,32'h0,0,        2'b10,2'b10,0,0));
        // Grant, then 1-cycle reset: no response, next conflict to host 0
        vq.push_back(mk(1,2'b01,2'b00,8'hFF,B+8,B+4,0,0,               2'b01,1,0,4'hF,32'h8,0,        2'b00,2'b00,0,0));
        vq.push_back(mk(0,2'b11,2'b00,8'hFF,B+8,B+4,0,0,               2'b00,0,0,4'h0,32'h0,0,        2'b00,2'b00,0,0));
        vq.push_back(mk(1,2'b11,2'b00,8'hFF,B+8,B+4,0,0,               2'b01,1,0,4'hF,32'h8,0,        2'b00,2'b00,0,0));
        vq.push_back(mk(1,2'b11,2'b00,8'hFF,B+8,B+4,0,0,               2'b10,1,0,4'hF,32'h4,0,        2'b01,2'b00,32'hDEADBEEF,0));
        vq.push_back(mk(1,2'b00,2'b00,8'hFF,B,B,0,0,                   2'b00,0,0,4'h0,32'h0,0,        2'b10,2'b00,0,32'h10000001));

        drive(vq[0]);
        repeat (3) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk); #1;
            drive(vq[i]);
            #3;
            check($sformatf("vec%0d", i), vq[i]);
        end

        // Stale RAM rvalid with nothing pending must be dropped
        @(posedge clk); #1;
        req = 2'b00; inject = 1'b1;
        #3;
        n_vec++;
        if (rvalid !== 2'b00 || rdata !== 64'h0) begin
            n_bad++;
            $display("FAIL stale_rvalid got rvalid=%b rdata=%h required rvalid=00 rdata=0", rvalid, rdata);
        end
        @(posedge clk); #1;
        inject = 1'b0;

        // Continuous conflict: strict alternation starting with host 0, responses one cycle behind
        prev_g = 2'b00;
        for (int i = 0; i < 8; i++) begin
            vec_t e;
            logic [1:0] g;
            g = (i % 2 == 0) ? 2'b01 : 2'b10;
            e = mk(1,2'b11,2'b00,8'hFF,B+8,B+4,0,0, g,1,0,4'hF,(g == 2'b01) ? 32'h8 : 32'h4,0,
                   prev_g,2'b00,
                   (prev_g == 2'b01) ? 32'hDEADBEEF : 32'h0,
                   (prev_g == 2'b10) ? 32'h10000001 : 32'h0);
            drive(e);
            #3;
            check($sformatf("conflict%0d", i), e);
            prev_g = g;
            @(posedge clk); #1;
        end
        req = 2'b00;
        @(posedge clk); #1;

        // RAM contents: only word 4 low half changed
        all_ok = 1'b1;
        for (int i = 0; i < 128; i++) begin
            logic [31:0] x;
            x = (i == 2) ? 32'hDEADBEEF : (i == 4) ? 32'h1122CCDD : 32'h1000_0000 + i;
            if (mem[i] !== x) begin
                all_ok = 1'b0;
                $display("FAIL mem_word%0d got=%h required=%h", i, mem[i], x);
            end
        end
        n_vec++;
        if (!all_ok) n_bad++;

        t = vq[0];
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_1p_arbiter.md
Name: ram_1p_arbiter

Overview:
- Two-host to one-port arbiter in front of the team's single-port 32-bit SRAM (ram_1p).
- Typical hosts: host 0 is core instruction fetch, host 1 is core data LSU. The block shares the single RAM port between them.
- Round-robin arbitration on conflict. Address-range check with a local error response for out-of-range accesses. Routes the 1-cycle-latency RAM response back to the host that issued the request.

Parameters:
- NumHosts, 2, number of requesters; fixed at 2, and the arbitration rule below depends on it.
- Depth, 128, RAM depth in 32-bit words; must match the attached ram_1p.
- BaseAddr, 32'h0010_0000, byte address of RAM word 0; aligned to Depth*4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- host_req_i  in  2  per-host request
- host_gnt_o  out  2  per-host grant; same-cycle, combinational
- host_we_i  in  2  per-host write enable
- host_be_i  in  2x4  per-host byte enables; host h uses bits [4h+3:4h]
- host_addr_i  in  2x32  per-host byte address
- host_wdata_i  in  2x32  per-host write data
- host_rvalid_o  out  2  per-host response valid
- host_err_o  out  2  per-host response error; qualified by host_rvalid_o
- host_rdata_o  out  2x32  per-host read data; 0 when err or not valid
- ram_req_o, ram_we_o  out  1 each  to ram_1p
- ram_be_o  out  4  to ram_1p
- ram_addr_o, ram_wdata_o  out  32 each  to ram_1p
- ram_rvalid_i  in  1  from ram_1p
- ram_rdata_i  in  32  from ram_1p

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Arbitration is combinational each cycle:
  - Only one host requesting: that host wins.
  - Both requesting: the host != last_q wins.
  - last_q updates to the winner on every grant. Reset value of last_q is 1, so host 0 wins the first conflict.
- host_gnt_o[w] = 1 for the winner w only; the loser sees gnt=0 and must hold its request (normal req/gnt protocol). At most one grant per cycle.
- Range check: in_range = (addr - BaseAddr) < Depth*4, evaluated on the winner's address using unsigned 32-bit subtraction (wrap makes addresses below BaseAddr out of range).
- In-range grant:
  - ram_req_o=1.
  - ram_we_o, ram_be_o and ram_wdata_o come from the winner.
  - ram_addr_o = addr - BaseAddr, so ram_1p indexes from word 0.
- Out-of-range grant:
  - ram_req_o=0; the write is discarded.
  - err_pend_q <= 1 and err_owner_q <= w.
- Response tracking: on an in-range grant, ram_owner_q <= w and ram_pend_q <= 1. With no in-range grant, ram_pend_q <= 0 (RAM latency is exactly 1 cycle).
- Response routing, cycle N+1 after a grant in cycle N:
  - If ram_pend_q: host_rvalid_o[ram_owner_q] = ram_rvalid_i, host_rdata_o = ram_rdata_i, err=0.
  - If err_pend_q: host_rvalid_o[err_owner_q] = 1, err=1, rdata=0.
  - ram_pend_q and err_pend_q are never both set, since there is one grant per cycle.
- Throughput: back-to-back grants are allowed, one per cycle. Alternating grants under continuous conflict give 50/50 bandwidth.
- ram_rvalid_i=1 while ram_pend_q=0 is dropped. This covers a stale response after reset.
- Reset:
  - Synchronous; in reset, all grants are forced to 0 and ram_req_o=0.
  - last_q=1; ram_pend_q, err_pend_q, ram_owner_q and err_owner_q all 0.
  - Reset value of all host_* and ram_* outputs is 0.
  - A transaction granted in the cycle before reset asserts receives no response.
- Unused outputs (ram_* fields when ram_req_o=0) are driven to 0.

Decomposition:
- Package ram_arb_pkg holds:
  - NumHosts.
  - The host_idx_t typedef (1 bit).
  - An rsp_src_e enum {RSP_NONE, RSP_RAM, RSP_ERR}.
- One sub-module, rr_arb2: two-input round-robin arbiter with the last_q register. Inputs req[1:0]; outputs gnt[1:0], winner index, valid. Reused for other shared peripherals.

Test Plan:
- Host0 single read of addr 0x0010_0008 (RAM word 2 preloaded 0xDEADBEEF) -> gnt0 same cycle, ram_addr_o=0x8, next cycle host_rvalid_o=2'b01, rdata=0xDEADBEEF, err=0.
- Both hosts request continuously for 4 cycles, all in range -> grants 0,1,0,1; each response appears 1 cycle after its grant, routed to the correct host with no cross-talk.
- Host1 write be=4'b0011 of 0xAABBCCDD to 0x0010_0010, then host0 reads the same address -> host0 rdata low half 0xCCDD, upper bytes keep prior contents.
- Host1 access to 0x0010_0200 (Depth=128, one past the end) and to 0x000F_FFFC -> ram_req_o=0, next cycle rvalid[1]=1, err[1]=1, rdata=0; RAM contents unchanged.
- Interleaved: host0 in range and host1 out of range on alternating cycles -> correct per-host rvalid/err each cycle, with no missed or duplicated responses.
- rst_ni low for 1 cycle right after a grant -> no rvalid to either host after reset, and the next conflict is granted to host 0.
